fence_point_server: RTL and testbench
=====================================

// Module: fence_point_server
// PURPOSE
// - Responder end of the point-fetch handshake driven by sys_ctrl: holds NUM_SETS point
//   sets of 7 points each in a loadable register file.
// - Returns the requested coordinate on X/Y in the same cycle i_valid/num are presented.
// - Collects each valid/is_inside answer into a result vector and checks protocol sanity.
// - Sits between the stimulus/load logic and the controller.
// PARAMETERS
// NUM_SETS  4   number of point sets served per run (>=1)
// CW        10  coordinate width, unsigned
// PTS       7   points per set; num 0 = object point, 1..PTS-1 = fence vertices
// PORTS
// clk        in   1              system clock, rising edge
// reset      in   1              asynchronous, active-high reset
// ld_en      in   1              write one point into the register file
// ld_set     in   clog2(NUM_SETS) set index of write
// ld_pt      in   3              point index of write
// ld_x       in   CW             X coordinate to write
// ld_y       in   CW             Y coordinate to write
// start      in   1              pulse: begin serving from set 0
// i_valid    in   1              controller requests point num this cycle
// num        in   3              requested point index
// valid      in   1              controller answer strobe for current set
// is_inside  in   1              answer bit, qualified by valid
// X          out  CW             served X coordinate (combinational)
// Y          out  CW             served Y coordinate (combinational)
// set_idx    out  clog2(NUM_SETS) set currently being served
// busy       out  1              high in SERVE
// done       out  1              high in DONE
// results    out  NUM_SETS       bit s = is_inside answer for set s
// inside_cnt out  clog2(NUM_SETS+1) count of sets answered inside
// err        out  3              sticky {stray_ans, short_set, range_err}
// BEHAVIOUR
// - Reset (async, active-high): state IDLE; set_idx=0, results=0, inside_cnt=0,
//   err=0, seen mask=0. Register file contents are NOT reset. X=Y=0.
// - FSM states: IDLE, SERVE, DONE.
//   - IDLE -start-> SERVE
//   - SERVE -valid on last set-> DONE
//   - DONE -start-> SERVE
//   - start while in SERVE is ignored.
// - On SERVE entry: set_idx=0, results=0, inside_cnt=0, seen=0, err cleared.
// - Load port: ld_en honoured only in IDLE/DONE; ignored in SERVE.
//   - Writes with ld_pt>=PTS are dropped.
// - X/Y: in SERVE with i_valid=1 and num<PTS, X/Y = mem[set_idx][num] in the same cycle
//   (zero latency). Otherwise X=Y=0.
// - Each served request sets seen[num]; repeated fetches of the same point are legal.
// - i_valid=1 with num>=PTS in SERVE: X=Y=0, err[0] (range_err) set.
// - valid=1 in SERVE:
//   - results[set_idx] <= is_inside; inside_cnt += is_inside.
//   - If seen != all ones, err[1] (short_set) is set; the answer is still recorded.
//   - seen is cleared.
//   - If set_idx==NUM_SETS-1, go to DONE with set_idx held; else set_idx += 1.
// - valid=1 outside SERVE: err[2] (stray_ans) set; results unchanged.
// - i_valid and valid in the same cycle: the request is served against the OLD set_idx;
//   it is not counted in the next set's seen mask.
// - err bits are sticky until the next SERVE entry or reset.
// - Reset mid-SERVE aborts to IDLE; the loaded points are retained.
// TESTING
// - Load set0 obj(5,5), fence pts; start; num=0..6 with i_valid -> X/Y match the loaded
//   values the same cycle, busy=1.
// - NUM_SETS=4, answers 1,0,1,1 -> results=4'b1101, inside_cnt=3, done=1, err=0.
// - valid after only num 0..3 fetched -> err=3'b010, answer still recorded, set_idx advances.
// - i_valid with num=7 -> X=Y=0, err[0]=1; valid pulse in IDLE -> err[2]=1.
// - Assert reset at set 2 mid-fetch -> IDLE, outputs 0; restart -> set0 coordinates intact.
// - ld_en in SERVE writing set0 pt0=(999,999) -> ignored; X stays at the old value.

Source files
------------

// File: rtl/fence_point_server_if.sv
// Point-fetch handshake between the controller (master) and the point server (slave).
// Controller drives i_valid/num for a fetch and valid/is_inside for an answer; the
// server returns X/Y combinationally in the same cycle as the request.
interface fence_point_server_if #(
    parameter int CW = 10
);
    logic          i_valid;    // request point num this cycle
    logic [2:0]    num;        // requested point index
    logic          valid;      // answer strobe for the current set
    logic          is_inside;  // answer bit, qualified by valid
    logic [CW-1:0] X;          // served X coordinate
    logic [CW-1:0] Y;          // served Y coordinate

    modport master (
        output i_valid, num, valid, is_inside,
        input  X, Y
    );

    modport slave (
        input  i_valid, num, valid, is_inside,
        output X, Y
    );
endinterface

// File: rtl/fence_point_server.sv
// Purpose: serves NUM_SETS point sets (object point + fence vertices) to the controller and
//          collects its inside/outside answers with protocol sanity flags.
// Latency: X/Y are combinational (zero latency); answers/status update on the next edge.
// Backpressure: none; every request/answer is accepted in the cycle it is presented.
// Ports:
//   clk, reset           clock and async active-high reset
//   ld_en/ld_set/ld_pt/ld_x/ld_y   register-file write port (honoured outside SERVE)
//   start                begins a serving run at set 0
//   pif (slave)          i_valid/num -> X/Y fetch, valid/is_inside answer
//   set_idx, busy, done  progress; results, inside_cnt answer summary; err sticky flags
module fence_point_server #(
    parameter int NUM_SETS = 4,
    parameter int CW       = 10,
    parameter int PTS      = 7,
    localparam int SW      = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
    localparam int CNTW    = $clog2(NUM_SETS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ld_en,
    input  logic [SW-1:0]        ld_set,
    input  logic [2:0]           ld_pt,
    input  logic [CW-1:0]        ld_x,
    input  logic [CW-1:0]        ld_y,
    input  logic                 start,
    fence_point_server_if.slave  pif,
    output logic [SW-1:0]        set_idx,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_SETS-1:0]  results,
    output logic [CNTW-1:0]      inside_cnt,
    output logic [2:0]           err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0]    PTS_L    = 4'(PTS);
    localparam logic [SW:0]   SETS_L   = (SW + 1)'(NUM_SETS);
    localparam logic [SW-1:0] LAST_SET = SW'(NUM_SETS - 1);

    // err bit positions
    localparam int E_RANGE = 0;
    localparam int E_SHORT = 1;
    localparam int E_STRAY = 2;

    state_t           state;
    logic [PTS-1:0]   seen;

    // Point storage; deliberately not reset so a run can be restarted after reset
    // without reloading.
    logic [CW-1:0]    mem_x [NUM_SETS][PTS];
    logic [CW-1:0]    mem_y [NUM_SETS][PTS];

    logic             in_serve;
    logic             num_ok;
    logic             serve_hit;
    logic             range_hit;
    logic [PTS-1:0]   hit_mask;
    logic             ld_ok;

    assign in_serve  = (state == SERVE);
    assign num_ok    = ({1'b0, pif.num} < PTS_L);
    assign serve_hit = in_serve && pif.i_valid && num_ok;
    assign range_hit = in_serve && pif.i_valid && !num_ok;
    assign hit_mask  = serve_hit ? ({{(PTS-1){1'b0}}, 1'b1} << pif.num) : '0;

    // Loads are frozen while serving so the controller sees a stable point set.
    assign ld_ok = ld_en && !in_serve
                && ({1'b0, ld_pt} < PTS_L)
                && ({1'b0, ld_set} < SETS_L);

    always_ff @(posedge clk) begin
        if (ld_ok) begin
            mem_x[ld_set][ld_pt] <= ld_x;
            mem_y[ld_set][ld_pt] <= ld_y;
        end
    end

    // Zero-latency fetch path; anything other than a legal request reads as zero.
    always_comb begin
        pif.X = '0;
        pif.Y = '0;
        if (serve_hit) begin
            pif.X = mem_x[set_idx][pif.num];
            pif.Y = mem_y[set_idx][pif.num];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            set_idx    <= '0;
            results    <= '0;
            inside_cnt <= '0;
            err        <= '0;
            seen       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= SERVE;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        set_idx    <= '0;
                        results    <= '0;
                        inside_cnt <= '0;
                        seen       <= '0;
                        // A stray answer coinciding with start still gets flagged.
                        err        <= {pif.valid, 2'b00};
                    end else if (pif.valid) begin
                        err[E_STRAY] <= 1'b1;
                    end
                end

                SERVE: begin
                    if (range_hit) begin
                        err[E_RANGE] <= 1'b1;
                    end
                    if (pif.valid) begin
                        results[set_idx] <= pif.is_inside;
                        inside_cnt       <= inside_cnt + CNTW'(pif.is_inside);
                        // A fetch in the answer cycle belongs to the set being closed,
                        // so it counts toward completeness here and is then discarded.
                        if (!(&(seen | hit_mask))) begin
                            err[E_SHORT] <= 1'b1;
                        end
                        seen <= '0;
                        if (set_idx == LAST_SET) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            set_idx <= set_idx + SW'(1);
                        end
                    end else begin
                        seen <= seen | hit_mask;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fence_point_server.sv
// Directed bench for fence_point_server: loads four point sets, runs full, short,
// out-of-range, simultaneous-answer, frozen-load, mid-run reset and stray-answer cases.
module tb_fence_point_server;

    localparam int NUM_SETS = 4;
    localparam int CW       = 10;
    localparam int PTS      = 7;

    logic          clk;
    logic          reset;
    logic          ld_en;
    logic [1:0]    ld_set;
    logic [2:0]    ld_pt;
    logic [CW-1:0] ld_x;
    logic [CW-1:0] ld_y;
    logic          start;
    logic [1:0]    set_idx;
    logic          busy;
    logic          done;
    logic [3:0]    results;
    logic [2:0]    inside_cnt;
    logic [2:0]    err;

    fence_point_server_if #(.CW(CW)) pif ();

    fence_point_server #(.NUM_SETS(NUM_SETS), .CW(CW), .PTS(PTS)) dut (
        .clk        (clk),
        .reset      (reset),
        .ld_en      (ld_en),
        .ld_set     (ld_set),
        .ld_pt      (ld_pt),
        .ld_x       (ld_x),
        .ld_y       (ld_y),
        .start      (start),
        .pif        (pif),
        .set_idx    (set_idx),
        .busy       (busy),
        .done       (done),
        .results    (results),
        .inside_cnt (inside_cnt),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Loaded coordinates: set0 point0 is the object at (5,5).
    function automatic logic [31:0] px(input int s, input int p);
        return 32'(s * 100 + p * 13 + 5);
    endfunction

    function automatic logic [31:0] py(input int s, input int p);
        return 32'(s * 100 + p * 17 + 5);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int s, input int p, input logic [31:0] x, input logic [31:0] y);
        ld_en  = 1'b1;
        ld_set = 2'(s);
        ld_pt  = 3'(p);
        ld_x   = CW'(x);
        ld_y   = CW'(y);
        tick();
        ld_en  = 1'b0;
    endtask

    // Fetch point p of set s and check the same-cycle coordinates.
    task automatic fetch(input int s, input int p);
        pif.i_valid = 1'b1;
        pif.num     = 3'(p);
        #1;
        check($sformatf("x_s%0d_p%0d", s, p), 32'(pif.X), px(s, p));
        check($sformatf("y_s%0d_p%0d", s, p), 32'(pif.Y), py(s, p));
        tick();
        pif.i_valid = 1'b0;
    endtask

    task automatic answer(input logic b);
        pif.valid     = 1'b1;
        pif.is_inside = b;
        tick();
        pif.valid     = 1'b0;
        pif.is_inside = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ld_en = 1'b0; ld_set = '0; ld_pt = '0; ld_x = '0; ld_y = '0;
        start = 1'b0;
        pif.i_valid = 1'b0; pif.num = '0; pif.valid = 1'b0; pif.is_inside = 1'b0;
        #12;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_set_idx", 32'(set_idx), 0);
        check("rst_results", 32'(results), 0);
        check("rst_inside_cnt", 32'(inside_cnt), 0);
        check("rst_err", 32'(err), 0);
        check("rst_x", 32'(pif.X), 0);
        reset = 1'b0;
        tick();

        for (int s = 0; s < NUM_SETS; s++)
            for (int p = 0; p < PTS; p++)
                load(s, p, px(s, p), py(s, p));
        // Point index 7 is out of range and must be dropped without side effects.
        load(0, 7, 32'd1, 32'd1);

        // Run A: all points fetched, answers 1,0,1,1.
        pulse_start();
        check("a_busy", 32'(busy), 1);
        check("a_set_idx0", 32'(set_idx), 0);
        for (int p = 0; p < PTS; p++) fetch(0, p);
        answer(1'b1);
        check("a_set_idx1", 32'(set_idx), 1);
        for (int p = 0; p < PTS; p++) fetch(1, p);
        answer(1'b0);
        for (int p = 0; p < PTS; p++) fetch(2, p);
        answer(1'b1);
        check("a_set_idx3", 32'(set_idx), 3);
        for (int p = 0; p < PTS; p++) fetch(3, p);
        answer(1'b1);
        check("a_done", 32'(done), 1);
        check("a_busy_end", 32'(busy), 0);
        check("a_results", 32'(results), 32'b1101);
        check("a_inside_cnt", 32'(inside_cnt), 3);
        check("a_err", 32'(err), 0);
        check("a_set_idx_held", 32'(set_idx), 3);
        pif.i_valid = 1'b1; pif.num = 3'd0;
        #1;
        check("a_done_x_zero", 32'(pif.X), 0);
        pif.i_valid = 1'b0;
        tick();

        // Run B: answer with a same-cycle fetch, frozen load, range error, mid-run reset.
        pulse_start();
        check("b_done_clr", 32'(done), 0);
        check("b_results_clr", 32'(results), 0);
        check("b_cnt_clr", 32'(inside_cnt), 0);
        check("b_set_idx_clr", 32'(set_idx), 0);
        for (int p = 0; p < PTS; p++) fetch(0, p);
        pif.valid = 1'b1; pif.is_inside = 1'b1;
        pif.i_valid = 1'b1; pif.num = 3'd0;
        #1;
        check("b_sim_x_old_set", 32'(pif.X), px(0, 0));
        tick();
        pif.valid = 1'b0; pif.is_inside = 1'b0; pif.i_valid = 1'b0;
        check("b_sim_set_idx", 32'(set_idx), 1);
        check("b_sim_err", 32'(err), 0);
        load(0, 0, 32'd999, 32'd999);
        // Point 0 of set 1 is only covered by the fetch in the answer cycle above.
        for (int p = 1; p < PTS; p++) fetch(1, p);
        answer(1'b0);
        check("b_short_err", 32'(err), 32'b010);
        check("b_short_set_idx", 32'(set_idx), 2);
        check("b_results", 32'(results), 32'b0001);
        pif.i_valid = 1'b1; pif.num = 3'd7;
        #1;
        check("b_range_x", 32'(pif.X), 0);
        check("b_range_y", 32'(pif.Y), 0);
        tick();
        pif.i_valid = 1'b0;
        check("b_range_err", 32'(err), 32'b011);
        for (int p = 0; p < 3; p++) fetch(2, p);
        pif.i_valid = 1'b1; pif.num = 3'd3;
        #2;
        reset = 1'b1;
        #1;
        check("b_rst_busy", 32'(busy), 0);
        check("b_rst_set_idx", 32'(set_idx), 0);
        check("b_rst_err", 32'(err), 0);
        check("b_rst_results", 32'(results), 0);
        check("b_rst_x", 32'(pif.X), 0);
        pif.i_valid = 1'b0;
        tick();
        #2;
        reset = 1'b0;
        tick();

        // Stray answer while idle.
        answer(1'b1);
        check("stray_err", 32'(err), 32'b100);
        check("stray_results", 32'(results), 0);
        check("stray_busy", 32'(busy), 0);

        // Run C: set0 intact after reset and frozen load; short set of points 0..3.
        pulse_start();
        check("c_err_clr", 32'(err), 0);
        for (int p = 0; p < 4; p++) fetch(0, p);
        answer(1'b1);
        check("c_short_err", 32'(err), 32'b010);
        check("c_results", 32'(results), 32'b0001);
        check("c_set_idx", 32'(set_idx), 1);
        check("c_inside_cnt", 32'(inside_cnt), 1);
        check("c_busy", 32'(busy), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
